// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the decimating FIR: FSM encoding,
// accumulator sizing and the round-half-up / saturate rule.
package fir_pkg;

   typedef enum logic [1:0] {CLEAR, IDLE, MAC, OUT} fir_state_t;

   // Working width for rounding; must exceed any accumulator width plus one guard bit.
   localparam int WIDE_W = 128;

   function automatic int acc_width(input int in_w, input int coeff_w, input int taps);
      return in_w + coeff_w + $clog2(taps);
   endfunction

   function automatic logic signed [WIDE_W-1:0] round_sat(
      input logic signed [WIDE_W-1:0] acc,
      input int                       shift,
      input int                       out_w
   );
      logic signed [WIDE_W-1:0] one;
      logic signed [WIDE_W-1:0] t;
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      one = WIDE_W'(1);
      t   = acc;
      if (shift > 0) t = t + (one <<< (shift - 1));
      t  = t >>> shift;
      hi = (one <<< (out_w - 1)) - one;
      lo = -(one <<< (out_w - 1));
      if (t > hi)      t = hi;
      else if (t < lo) t = lo;
      return t;
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of the
// accumulator down to the output width.
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int ACC_W     = 73,
   parameter int OUT_W     = 50,
   parameter int OUT_SHIFT = 17
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] res
);

   assign res = OUT_W'(round_sat(WIDE_W'(acc), OUT_SHIFT, OUT_W));

endmodule

// File: rtl/fir_decim_mac.sv
// Multi-channel decimating FIR: one shared MAC over taps and channels, per-channel
// circular history in a single sample memory, runtime-loadable coefficients.
module fir_decim_mac
   import fir_pkg::*;
#(
   parameter int IN_W      = 50,
   parameter int COEFF_W   = 18,
   parameter int NUM_TAPS  = 26,
   parameter int R         = 2,
   parameter int NUM_CH    = 1,
   parameter int OUT_W     = 50,
   parameter int OUT_SHIFT = 17,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [IN_W-1:0]    in_data,
   input  logic        [CH_W-1:0]    in_ch,
   input  logic                      coef_we,
   input  logic        [TAP_W-1:0]   coef_addr,
   input  logic signed [COEFF_W-1:0] coef_wdata,
   output logic                      coef_err,
   output logic                      out_valid,
   output logic signed [OUT_W-1:0]   out_data,
   output logic        [CH_W-1:0]    out_ch
);

   localparam int ACC_W  = acc_width(IN_W, COEFF_W, NUM_TAPS);
   localparam int PROD_W = IN_W + COEFF_W;
   localparam int DEPTH  = NUM_CH * NUM_TAPS;
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PH_W   = (R > 1) ? $clog2(R) : 1;

   fir_state_t state, state_nxt;

   logic        [AW-1:0]      clr_cnt;
   logic        [TAP_W-1:0]   k_cnt;
   logic        [TAP_W-1:0]   rd_ptr;
   logic        [CH_W-1:0]    ch_lat;
   logic        [TAP_W-1:0]   wptr  [NUM_CH];
   logic        [PH_W-1:0]    phase [NUM_CH];
   logic signed [COEFF_W-1:0] coef  [NUM_TAPS];
   logic signed [IN_W-1:0]    mem   [DEPTH];

   logic signed [PROD_W-1:0]  prod_p1;
   logic signed [ACC_W-1:0]   acc;
   logic signed [OUT_W-1:0]   rs_out;
   logic                      vld_p1, last_p1, last_p2;

   logic            ch_ok, take, dec_done, coef_ok;
   logic [CH_W-1:0] ch_sel;
   logic [AW-1:0]   wr_addr, rd_addr;

   assign in_ready = (state == IDLE);
   assign ch_ok    = (int'(in_ch) < NUM_CH);
   assign ch_sel   = ch_ok ? in_ch : '0;
   assign take     = in_valid && in_ready && ch_ok;
   assign dec_done = take && (phase[ch_sel] == PH_W'(R - 1));
   assign coef_ok  = coef_we && (state == IDLE) && (int'(coef_addr) < NUM_TAPS);
   assign wr_addr  = AW'(int'(ch_sel) * NUM_TAPS + int'(wptr[ch_sel]));
   assign rd_addr  = AW'(int'(ch_lat) * NUM_TAPS + int'(rd_ptr));

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == AW'(DEPTH - 1)) state_nxt = IDLE;
         IDLE:    if (dec_done) state_nxt = MAC;
         MAC:     if (k_cnt == TAP_W'(NUM_TAPS - 1)) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR;
         clr_cnt   <= '0;
         k_cnt     <= '0;
         rd_ptr    <= '0;
         ch_lat    <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            wptr[c]  <= '0;
            phase[c] <= '0;
         end
         for (int t = 0; t < NUM_TAPS; t++) coef[t] <= '0;
         coef_err  <= 1'b0;
         vld_p1    <= 1'b0;
         last_p1   <= 1'b0;
         last_p2   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else begin
         state    <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (coef_ok) coef[coef_addr] <= coef_wdata;
         coef_err <= coef_we && !coef_ok;
         if (take) begin
            wptr[ch_sel]  <= (wptr[ch_sel] == TAP_W'(NUM_TAPS - 1)) ? '0 : wptr[ch_sel] + 1'b1;
            phase[ch_sel] <= dec_done ? '0 : phase[ch_sel] + 1'b1;
         end
         // The newest sample sits at the pre-increment write pointer; walk backwards from it.
         if (dec_done) begin
            ch_lat <= ch_sel;
            rd_ptr <= wptr[ch_sel];
            k_cnt  <= '0;
         end else if (state == MAC) begin
            rd_ptr <= (rd_ptr == '0) ? TAP_W'(NUM_TAPS - 1) : rd_ptr - 1'b1;
            k_cnt  <= k_cnt + 1'b1;
         end
         vld_p1    <= (state == MAC);
         last_p1   <= (state == MAC) && (k_cnt == TAP_W'(NUM_TAPS - 1));
         last_p2   <= last_p1;
         // output stage: register the rounded, saturated result
         out_valid <= last_p2;
         if (last_p2) begin
            out_data <= rs_out;
            out_ch   <= ch_lat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      else if (take)      mem[wr_addr] <= in_data;
   end

   always_ff @(posedge clk) begin
      // stage p1: one tap product per MAC cycle
      if (state == MAC) prod_p1 <= PROD_W'(mem[rd_addr]) * PROD_W'(coef[k_cnt]);
      // stage p2: full-precision accumulate
      if (dec_done)    acc <= '0;
      else if (vld_p1) acc <= acc + ACC_W'(prod_p1);
   end

   fir_round_sat #(
      .ACC_W     (ACC_W),
      .OUT_W     (OUT_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_round_sat (
      .acc (acc),
      .res (rs_out)
   );

endmodule
